multi_cnt: RTL and testbench
============================

MULTI_CNT -- requirements
Module: multi_cnt

Interface
REQ-001 SHALL provide parameter DW, default 11: width of count and data values.
REQ-002 SHALL provide parameter NCH, default 4: number of independent counter channels (1..16).
REQ-003 SHALL provide parameter CW, default $clog2(NCH) with minimum 1: channel-index width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 irdy  input  NCH  per-channel load request from upstream.
REQ-007 iack  output  NCH  per-channel load accept; a load transfers when irdy[c] && iack[c].
REQ-008 iint  input  NCH x DW  per-channel length N.
REQ-009 imode  input  NCH  per-channel direction, sampled with the load: 0 = up, 1 = down.
REQ-010 ordy  output  1  output beat valid.
REQ-011 oack  input  1  downstream accept; a beat transfers when ordy && oack.
REQ-012 oint  output  DW  output beat value.
REQ-013 och  output  CW  source channel of the current beat.
REQ-014 olast  output  1  current beat is the final beat of its channel's sequence.

Function
REQ-015 Each channel SHALL be IDLE or BUSY; iack[c] SHALL be 1 exactly when channel c is IDLE, driven from registered state only.
REQ-016 A load on channel c with N > 0 SHALL capture N and imode[c] and move the channel to BUSY on the next edge.
REQ-017 A load with N == 0 SHALL be accepted, SHALL produce no beats, and SHALL leave the channel IDLE.
REQ-018 A BUSY channel in up mode SHALL emit 0, 1, ..., N-1; in down mode it SHALL emit N-1, ..., 0; N SHALL range 1..2^DW-1, with no wrap-around.
REQ-019 The final beat of a sequence SHALL have olast = 1; all other beats SHALL have olast = 0.
REQ-020 A channel SHALL return to IDLE on the edge at which its final beat transfers downstream; iack[c] SHALL rise in the following cycle.
REQ-021 Output SHALL be a single registered slot; ordy, oint, och and olast SHALL be register outputs.
REQ-022 While ordy = 1 and oack = 0, oint, och and olast SHALL hold stable and ordy SHALL stay 1.
REQ-023 The slot SHALL refill on the same edge it transfers (ordy && oack), so one channel can sustain one beat per cycle.
REQ-024 Minimum latency SHALL be: load transfers at edge t, first beat ordy = 1 after edge t+1.
REQ-025 A channel SHALL have at most one beat in the slot; its next value SHALL be issued only after that beat transfers.
REQ-026 Slot fill SHALL use round-robin arbitration among BUSY channels with no beat in the slot; after channel c is granted, highest priority SHALL move to c+1 mod NCH.
REQ-027 With a single contending channel, that channel SHALL be granted every eligible cycle regardless of the pointer.
REQ-028 irdy asserted to a BUSY channel SHALL be ignored with no state change; iint and imode SHALL be don't-care when irdy = 0.
REQ-029 Loads on several channels in the same cycle SHALL all be accepted independently.

Reset
REQ-030 When rst = 0, all channels SHALL go IDLE (iack = all ones), ordy = 0, oint = 0, och = 0, olast = 0, and the round-robin pointer = 0, immediately and without waiting for clk.
REQ-031 Reset mid-sequence SHALL discard any in-slot beat and all remaining counts; no beat from before reset SHALL appear after rst returns to 1.
REQ-032 The first clk edge with rst = 1 SHALL be able to accept loads.

Verification
REQ-033 Channel 0 loaded with N = 5, up mode, oack held 1 -> oint 0,1,2,3,4 on consecutive cycles, och = 0, olast only on 4, iack[0] rises the cycle after 4 transfers.
REQ-034 Channel 2 loaded with N = 3, down mode -> oint 2,1,0, olast on 0; a load of N = 0 on channel 1 -> iack[1] stays 1 and no beats appear.
REQ-035 Channels 0..3 loaded with N = 2 in the same cycle, oack = 1 -> och sequence 0,1,2,3,0,1,2,3 with values 0,0,0,0,1,1,1,1.
REQ-036 Random oack (50%) with N = 100 on two channels -> no beat dropped or duplicated, outputs stable while stalled, 200 beats total.
REQ-037 rst pulled low mid-sequence (N = 10, after 4 beats) -> ordy = 0 and iack all ones asynchronously; no stale beats after release; a new load of N = 1 yields a single beat oint = 0, olast = 1.
REQ-038 DW = 4, NCH = 1, N = 15 in up mode -> beats 0..14, with no wrap and no extra beat.

Source files
------------

// File: rtl/multi_cnt.sv
// Multi-channel sequence counter.
// Each channel accepts a length N and emits N beats (0..N-1 up, or N-1..0 down)
// through one shared registered output slot, with round-robin arbitration
// between the channels that are waiting to issue their next value.
//
// Channel state (one bit per channel, r_busy):
//   state | meaning
//   IDLE  | iack = 1, waiting for a load
//   BUSY  | sequence in progress; returns to IDLE when its final beat transfers
module multi_cnt #(
  parameter int DW  = 11,
  parameter int NCH = 4,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          irdy,
  output logic [NCH-1:0]          iack,
  input  logic [NCH-1:0][DW-1:0]  iint,
  input  logic [NCH-1:0]          imode,
  output logic                    ordy,
  input  logic                    oack,
  output logic [DW-1:0]           oint,
  output logic [CW-1:0]           och,
  output logic                    olast
);

  logic [NCH-1:0]          r_busy;
  logic [NCH-1:0]          r_mode;
  logic [NCH-1:0][DW-1:0]  r_len;
  logic [NCH-1:0][DW-1:0]  r_rem;   // values not yet issued into the slot
  logic [CW-1:0]           r_ptr;
  logic                    r_ordy;
  logic [DW-1:0]           r_oint;
  logic [CW-1:0]           r_och;
  logic                    r_olast;

  logic [NCH-1:0]          w_busy_nxt;
  logic [NCH-1:0]          w_load;
  logic [NCH-1:0]          w_elig;
  logic                    w_xfer;
  logic                    w_fill;
  logic                    w_gnt_vld;
  logic [CW-1:0]           w_gnt;
  logic [CW-1:0]           w_ptr_nxt;
  logic [DW-1:0]           w_val;
  logic                    w_last;

  assign w_xfer = r_ordy && oack;
  // The slot may be written when empty or when its beat leaves on this edge.
  assign w_fill = !r_ordy || oack;

  // Channel state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= w_busy_nxt;
  end

  // Next-state: IDLE->BUSY on a non-empty load, BUSY->IDLE when the final beat transfers.
  always_comb begin
    w_busy_nxt = r_busy;
    w_load     = '0;
    for (int c = 0; c < NCH; c++) begin
      w_load[c] = irdy[c] && !r_busy[c];
      if (r_busy[c]) begin
        if (w_xfer && r_olast && (r_och == CW'(c))) w_busy_nxt[c] = 1'b0;
      end else if (w_load[c] && (iint[c] != '0)) begin
        w_busy_nxt[c] = 1'b1;
      end
    end
  end

  // Outputs decoded from the state register alone.
  always_comb begin
    iack = ~r_busy;
  end

  // Eligible: busy, values left to issue, and no beat of its own stuck in the slot.
  always_comb begin
    w_elig = '0;
    for (int c = 0; c < NCH; c++) begin
      w_elig[c] = r_busy[c] && (r_rem[c] != '0) &&
                  !(r_ordy && !oack && (r_och == CW'(c)));
    end
  end

  // Round-robin pick starting from r_ptr.
  always_comb begin
    int k;
    k         = 0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int i = 0; i < NCH; i++) begin
      k = int'(r_ptr) + i;
      if (k >= NCH) k = k - NCH;
      if (!w_gnt_vld && w_elig[CW'(k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = CW'(k);
      end
    end
    w_ptr_nxt = (int'(w_gnt) == NCH - 1) ? '0 : w_gnt + CW'(1);
    w_val     = r_mode[w_gnt] ? (r_rem[w_gnt] - DW'(1)) : (r_len[w_gnt] - r_rem[w_gnt]);
    w_last    = (r_rem[w_gnt] == DW'(1));
  end

  // Per-channel length/direction capture and remaining-count down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode <= '0;
      r_len  <= '0;
      r_rem  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_load[c]) begin
          r_mode[c] <= imode[c];
          r_len[c]  <= iint[c];
          r_rem[c]  <= iint[c];
        end else if (w_fill && w_gnt_vld && (w_gnt == CW'(c))) begin
          r_rem[c]  <= r_rem[c] - DW'(1);
        end
      end
    end
  end

  // Output slot and arbitration pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ordy  <= 1'b0;
      r_oint  <= '0;
      r_och   <= '0;
      r_olast <= 1'b0;
      r_ptr   <= '0;
    end else if (w_fill && w_gnt_vld) begin
      r_ordy  <= 1'b1;
      r_oint  <= w_val;
      r_och   <= w_gnt;
      r_olast <= w_last;
      r_ptr   <= w_ptr_nxt;
    end else if (w_xfer) begin
      r_ordy  <= 1'b0;
    end
  end

  assign ordy  = r_ordy;
  assign oint  = r_oint;
  assign och   = r_och;
  assign olast = r_olast;

endmodule

// File: tb/tb_multi_cnt.sv
// Testbench for multi_cnt: vector table of single-channel loads plus
// hand-written sequences for arbitration, back-pressure, reset and a narrow build.
module tb_multi_cnt;

  localparam int DW  = 11;
  localparam int NCH = 4;

  logic                    clk;
  logic                    rst;
  logic [NCH-1:0]          irdy;
  logic [NCH-1:0]          iack;
  logic [NCH-1:0][DW-1:0]  iint;
  logic [NCH-1:0]          imode;
  logic                    ordy;
  logic                    oack;
  logic [DW-1:0]           oint;
  logic [1:0]              och;
  logic                    olast;

  logic                    s_irdy;
  logic                    s_iack;
  logic [0:0][3:0]         s_iint;
  logic                    s_imode;
  logic                    s_ordy;
  logic                    s_oack;
  logic [3:0]              s_oint;
  logic [0:0]              s_och;
  logic                    s_olast;

  multi_cnt #(.DW(DW), .NCH(NCH)) u_dut (
    .clk(clk), .rst(rst), .irdy(irdy), .iack(iack), .iint(iint), .imode(imode),
    .ordy(ordy), .oack(oack), .oint(oint), .och(och), .olast(olast)
  );

  multi_cnt #(.DW(4), .NCH(1)) u_small (
    .clk(clk), .rst(rst), .irdy(s_irdy), .iack(s_iack), .iint(s_iint), .imode(s_imode),
    .ordy(s_ordy), .oack(s_oack), .oint(s_oint), .och(s_och), .olast(s_olast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int ch;
    int n;
    bit mode;
    int first;
    int last;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int e;
    @(negedge clk);
    irdy[v.ch]  = 1'b1;
    iint[v.ch]  = DW'(v.n);
    imode[v.ch] = v.mode;
    oack        = 1'b1;
    @(negedge clk);
    irdy = '0;
    chk("load_ordy_low", 32'(ordy), 0);
    if (v.n == 0) begin
      repeat (4) begin
        chk("zero_iack_high", 32'(iack[v.ch]), 1);
        chk("zero_no_beat", 32'(ordy), 0);
        @(negedge clk);
      end
    end else begin
      chk("load_busy", 32'(iack[v.ch]), 0);
      for (int i = 0; i < v.n; i++) begin
        @(negedge clk);
        e = v.mode ? (v.n - 1 - i) : i;
        chk("vec_ordy", 32'(ordy), 1);
        chk("vec_oint", 32'(oint), 32'(e));
        chk("vec_och", 32'(och), 32'(v.ch));
        chk("vec_olast", 32'(olast), 32'(i == v.n - 1));
        if (i == 0)       chk("vec_first", 32'(oint), 32'(v.first));
        if (i == v.n - 1) chk("vec_final", 32'(oint), 32'(v.last));
      end
      @(negedge clk);
      chk("vec_iack_back", 32'(iack[v.ch]), 1);
      chk("vec_no_extra", 32'(ordy), 0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_ordy", 32'(ordy), 0);
    chk("rst_async_iack", 32'(iack), 32'hF);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int got[NCH];
    int total;
    int c;
    int e;
    bit prev_stall;
    logic [DW-1:0] p_oint;
    logic [1:0]    p_och;
    logic          p_olast;

    vecs[0] = '{ch: 0, n: 5,  mode: 1'b0, first: 0, last: 4};
    vecs[1] = '{ch: 2, n: 3,  mode: 1'b1, first: 2, last: 0};
    vecs[2] = '{ch: 1, n: 0,  mode: 1'b0, first: 0, last: 0};
    vecs[3] = '{ch: 3, n: 1,  mode: 1'b1, first: 0, last: 0};
    vecs[4] = '{ch: 1, n: 7,  mode: 1'b1, first: 6, last: 0};
    vecs[5] = '{ch: 3, n: 12, mode: 1'b0, first: 0, last: 11};

    rst = 1'b0; irdy = '0; iint = '0; imode = '0; oack = 1'b0;
    s_irdy = 1'b0; s_iint = '0; s_imode = 1'b0; s_oack = 1'b0;
    #1;
    chk("reset_iack", 32'(iack), 32'hF);
    chk("reset_ordy", 32'(ordy), 0);
    chk("reset_oint", 32'(oint), 0);
    chk("reset_och", 32'(och), 0);
    chk("reset_olast", 32'(olast), 0);
    chk("reset_small_iack", 32'(s_iack), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Four channels loaded together; pointer starts at 0 after reset.
    pulse_reset();
    @(negedge clk);
    irdy = 4'hF; oack = 1'b1;
    for (int k = 0; k < NCH; k++) begin iint[k] = DW'(2); imode[k] = 1'b0; end
    @(negedge clk);
    iint = {NCH{DW'(9)}};   // loads to busy channels must be ignored
    chk("all_busy", 32'(iack), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) irdy = '0;
      chk("rr_ordy", 32'(ordy), 1);
      chk("rr_och", 32'(och), 32'(i % 4));
      chk("rr_oint", 32'(oint), 32'(i / 4));
      chk("rr_olast", 32'(olast), 32'(i >= 4));
    end
    repeat (3) begin
      @(negedge clk);
      chk("rr_no_extra", 32'(ordy), 0);
      chk("rr_iack_back", 32'(iack), 32'hF);
    end

    // Two channels of 100 under random back-pressure.
    @(negedge clk);
    irdy = 4'b1010; oack = 1'b0;
    iint[1] = DW'(100); imode[1] = 1'b0;
    iint[3] = DW'(100); imode[3] = 1'b1;
    @(negedge clk);
    irdy = '0;
    got = '{default: 0};
    total = 0;
    prev_stall = 1'b0;
    p_oint = '0; p_och = '0; p_olast = 1'b0;
    for (int cyc = 0; cyc < 3000 && total < 200; cyc++) begin
      if (prev_stall) begin
        chk("stall_ordy", 32'(ordy), 1);
        chk("stall_oint", 32'(oint), 32'(p_oint));
        chk("stall_och", 32'(och), 32'(p_och));
        chk("stall_olast", 32'(olast), 32'(p_olast));
      end
      oack = 1'($urandom_range(0, 1));
      if (ordy && oack) begin
        c = int'(och);
        if (c != 1 && c != 3) begin
          chk("bp_och", 32'(c), 1);
        end else begin
          e = (c == 1) ? got[c] : 99 - got[c];
          chk("bp_oint", 32'(oint), 32'(e));
          chk("bp_olast", 32'(olast), 32'(got[c] == 99));
          got[c]++;
          total++;
        end
      end
      prev_stall = ordy && !oack;
      p_oint = oint; p_och = och; p_olast = olast;
      @(negedge clk);
    end
    chk("bp_total", 32'(total), 200);
    chk("bp_ch1", 32'(got[1]), 100);
    chk("bp_ch3", 32'(got[3]), 100);
    oack = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_drained", 32'(ordy), 0);
    chk("bp_iack", 32'(iack), 32'hF);

    // Reset in the middle of a sequence.
    irdy[0] = 1'b1; iint[0] = DW'(10); imode[0] = 1'b0;
    @(negedge clk);
    irdy = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("pre_rst_oint", 32'(oint), 32'(i));
    end
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ordy", 32'(ordy), 0);
    chk("mid_rst_iack", 32'(iack), 32'hF);
    chk("mid_rst_oint", 32'(oint), 0);
    chk("mid_rst_och", 32'(och), 0);
    chk("mid_rst_olast", 32'(olast), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    irdy[2] = 1'b1; iint[2] = DW'(1); imode[2] = 1'b0;
    @(negedge clk);
    irdy = '0;
    chk("post_rst_accept", 32'(iack), 32'b1011);
    chk("post_rst_ordy", 32'(ordy), 0);
    @(negedge clk);
    chk("post_rst_beat", 32'(ordy), 1);
    chk("post_rst_oint", 32'(oint), 0);
    chk("post_rst_och", 32'(och), 2);
    chk("post_rst_olast", 32'(olast), 1);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(ordy), 0);
    end
    chk("post_rst_iack", 32'(iack), 32'hF);

    // Narrow build: N at its maximum, no wrap.
    @(negedge clk);
    s_irdy = 1'b1; s_iint[0] = 4'd15; s_imode = 1'b0; s_oack = 1'b1;
    @(negedge clk);
    s_irdy = 1'b0;
    chk("small_busy", 32'(s_iack), 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("small_ordy", 32'(s_ordy), 1);
      chk("small_oint", 32'(s_oint), 32'(i));
      chk("small_olast", 32'(s_olast), 32'(i == 14));
    end
    repeat (3) begin
      @(negedge clk);
      chk("small_no_extra", 32'(s_ordy), 0);
    end
    chk("small_iack", 32'(s_iack), 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
